// File: rtl/atm_multi_account_ctrl.sv
// atm_multi_account_ctrl: multi-account ATM transaction engine; define ATM_REPORT_EN for per-account tx_count/last_amount reporting (op 4)
module atm_multi_account_ctrl #(
  parameter int NUM_ACCOUNTS = 8,
  parameter int AMT_W = 16,
  parameter int PW_W = 10,
  parameter int DATE_W = 11,
  parameter int CURRENT_DATE = 2022,
  parameter int MAX_TRIES = 3,
  parameter int MIN_BALANCE = 100,
  parameter int UNBAN_COST = 100,
  parameter int INIT_BALANCE = 1000,
  localparam int ACCT_W = $clog2(NUM_ACCOUNTS)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [2:0]        i_req_op,
  input  logic [ACCT_W-1:0] i_req_card,
  input  logic [ACCT_W-1:0] i_req_dest,
  input  logic [AMT_W-1:0]  i_req_amount,
  input  logic [DATE_W-1:0] i_req_exp_date,
  input  logic [PW_W-1:0]   i_req_password,
  input  logic [PW_W-1:0]   i_req_new_password,
  output logic              o_resp_valid,
  output logic [2:0]        o_resp_status,
  output logic [AMT_W-1:0]  o_resp_balance,
  output logic [7:0]        o_resp_tx_count,
  output logic [AMT_W-1:0]  o_resp_last_amount
);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [2:0] ST_OK = 3'd0, ST_BAD_CARD = 3'd1, ST_BAD_PW = 3'd2, ST_BANNED = 3'd3;
  localparam logic [2:0] ST_INSUF = 3'd4, ST_BAD_DEST = 3'd5, ST_BAD_OP = 3'd6, ST_OVF = 3'd7;
  localparam logic [AMT_W:0] MIN_X = (AMT_W+1)'(MIN_BALANCE);
  localparam logic [AMT_W-1:0] UNBAN_X = AMT_W'(UNBAN_COST);
  localparam logic [AMT_W-1:0] INIT_X = AMT_W'(INIT_BALANCE);
  localparam logic [DATE_W-1:0] DATE_X = DATE_W'(CURRENT_DATE);
  localparam logic [TRY_W-1:0] MAX_X = TRY_W'(MAX_TRIES);
`ifdef ATM_REPORT_EN
  localparam logic [2:0] ST_RPT = ST_OK;
`else
  localparam logic [2:0] ST_RPT = ST_BAD_OP;
`endif
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EXEC, S_RESP} state_t;
  state_t r_state, w_state_nxt;
  logic [2:0]        r_op;
  logic [ACCT_W-1:0] r_card, r_dest;
  logic [AMT_W-1:0]  r_amount;
  logic [DATE_W-1:0] r_exp;
  logic [PW_W-1:0]   r_pw, r_new_pw;
  logic [2:0]        r_chk_status;
  logic [AMT_W-1:0]  r_bal [NUM_ACCOUNTS];
  logic [PW_W-1:0]   r_pw_tab [NUM_ACCOUNTS];
  logic [TRY_W-1:0]  r_tries [NUM_ACCOUNTS];
  logic              r_ban [NUM_ACCOUNTS];
  logic [2:0]        r_resp_status;
  logic [AMT_W-1:0]  r_resp_bal;
  logic              w_pw_ok, w_banned, w_enough, w_ok, w_debit, w_unban;
  logic [2:0]        w_chk_status, w_exec_status;
  logic [TRY_W-1:0]  w_tries_inc, w_tries_nxt;
  logic              w_ban_nxt;
  logic [AMT_W-1:0]  w_src, w_dst, w_src_new;
  logic [AMT_W:0]    w_sum;

  // State register; reset abandons any request in flight
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end

  // Fixed-latency sequencing: accept in IDLE, respond three cycles later
  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    o_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        w_state_nxt = i_req_valid ? S_CHECK : S_IDLE;
      end
      S_CHECK: w_state_nxt = S_EXEC;
      S_EXEC: w_state_nxt = S_RESP;
      default: begin
        o_resp_valid = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture on accept and latch of the credential-check verdict
  always_ff @(posedge i_clock) begin
    if (i_req_valid && o_req_ready) begin
      r_op <= i_req_op;
      r_card <= i_req_card;
      r_dest <= i_req_dest;
      r_amount <= i_req_amount;
      r_exp <= i_req_exp_date;
      r_pw <= i_req_password;
      r_new_pw <= i_req_new_password;
    end
    if (r_state == S_CHECK) r_chk_status <= w_chk_status;
  end

  // Credential checks in priority order plus wrong-password try bookkeeping
  always_comb begin
    w_pw_ok = r_pw_tab[r_card] == r_pw;
    w_banned = r_ban[r_card];
    w_tries_inc = r_tries[r_card] + TRY_W'(1);
    w_chk_status = r_exp < DATE_X ? ST_BAD_CARD :
                   (w_banned && r_op != 3'd6) ? ST_BANNED :
                   !w_pw_ok ? ST_BAD_PW :
                   (r_op == 3'd0 || r_op == 3'd7) ? ST_BAD_OP : ST_OK;
    w_tries_nxt = r_tries[r_card];
    w_ban_nxt = w_banned;
    if (w_chk_status == ST_BAD_PW && !w_banned) begin
      w_tries_nxt = w_tries_inc >= MAX_X ? MAX_X : w_tries_inc;
      w_ban_nxt = w_tries_inc >= MAX_X;
    end
    if (r_exp >= DATE_X && !w_banned && w_pw_ok) w_tries_nxt = '0;
  end

  // Operation execution; a zero amount never touches balances
  always_comb begin
    w_src = r_bal[r_card];
    w_dst = r_bal[r_dest];
    w_sum = {1'b0, w_dst} + {1'b0, r_amount};
    w_enough = (r_amount == '0) || ({1'b0, w_src} >= {1'b0, r_amount} + MIN_X);
    w_exec_status = r_chk_status != ST_OK ? r_chk_status :
                    (r_op == 3'd1 || r_op == 3'd5) ? ST_OK :
                    r_op == 3'd2 ? (w_enough ? ST_OK : ST_INSUF) :
                    r_op == 3'd3 ? (r_dest == r_card ? ST_BAD_DEST : !w_enough ? ST_INSUF : w_sum[AMT_W] ? ST_OVF : ST_OK) :
                    r_op == 3'd6 ? ((!w_banned || w_src >= UNBAN_X) ? ST_OK : ST_INSUF) :
                    r_op == 3'd4 ? ST_RPT : ST_BAD_OP;
    w_ok = w_exec_status == ST_OK;
    w_debit = w_ok && (r_op == 3'd2 || r_op == 3'd3) && r_amount != '0;
    w_unban = w_ok && r_op == 3'd6 && w_banned;
    w_src_new = w_debit ? w_src - r_amount : w_unban ? w_src - UNBAN_X : w_src;
  end

  // Account table: reset image, try/ban updates in CHECK, commits in EXEC
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_bal[i] <= INIT_X;
        r_pw_tab[i] <= PW_W'(i);
        r_tries[i] <= '0;
        r_ban[i] <= 1'b0;
      end
    end else if (r_state == S_CHECK) begin
      r_tries[r_card] <= w_tries_nxt;
      r_ban[r_card] <= w_ban_nxt;
    end else if (r_state == S_EXEC && w_ok) begin
      r_bal[r_card] <= w_src_new;
      if (r_op == 3'd3 && r_amount != '0) r_bal[r_dest] <= w_sum[AMT_W-1:0];
      if (r_op == 3'd5) r_pw_tab[r_card] <= r_new_pw;
      if (w_unban) begin
        r_ban[r_card] <= 1'b0;
        r_tries[r_card] <= '0;
      end
    end
  end

  // Response status and source balance, held between responses
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_resp_status <= ST_OK;
      r_resp_bal <= '0;
    end else if (r_state == S_EXEC) begin
      r_resp_status <= w_exec_status;
      r_resp_bal <= w_src_new;
    end
  end

  assign o_resp_status = r_resp_status;
  assign o_resp_balance = r_resp_bal;

`ifdef ATM_REPORT_EN
  logic [7:0]       r_tx [NUM_ACCOUNTS];
  logic [AMT_W-1:0] r_last [NUM_ACCOUNTS];
  logic [7:0]       r_resp_tx;
  logic [AMT_W-1:0] r_resp_last;

  // Per-account activity record and op 4 report latch
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        r_tx[i] <= '0;
        r_last[i] <= '0;
      end
      r_resp_tx <= '0;
      r_resp_last <= '0;
    end else if (r_state == S_EXEC) begin
      if (w_debit || w_unban) begin
        r_tx[r_card] <= r_tx[r_card] == 8'hFF ? 8'hFF : r_tx[r_card] + 8'd1;
        r_last[r_card] <= w_unban ? UNBAN_X : r_amount;
      end
      if (w_debit && r_op == 3'd3) begin
        r_tx[r_dest] <= r_tx[r_dest] == 8'hFF ? 8'hFF : r_tx[r_dest] + 8'd1;
        r_last[r_dest] <= r_amount;
      end
      r_resp_tx <= (w_ok && r_op == 3'd4) ? r_tx[r_card] : '0;
      r_resp_last <= (w_ok && r_op == 3'd4) ? r_last[r_card] : '0;
    end
  end

  assign o_resp_tx_count = r_resp_tx;
  assign o_resp_last_amount = r_resp_last;
`else
  assign o_resp_tx_count = '0;
  assign o_resp_last_amount = '0;
`endif
endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// tb_atm_multi_account_ctrl: scoreboard bench with a behavioural account model
module tb_atm_multi_account_ctrl;
  // narrow balances so the credit-overflow path is reachable from the reset image
  localparam int N = 8, AW = 11, AMAX = (1 << AW) - 1;
  logic clk = 0, rst_n = 0, req_valid = 0, req_ready, resp_valid;
  logic [2:0] req_op = 0, resp_status;
  logic [2:0] req_card = 0, req_dest = 0;
  logic [AW-1:0] req_amount = 0, resp_balance, resp_last;
  logic [10:0] req_date = 0;
  logic [9:0] req_pw = 0, req_npw = 0;
  logic [7:0] resp_tx;

  always #5 clk = ~clk;

  atm_multi_account_ctrl #(.AMT_W(AW)) u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_op(req_op), .i_req_card(req_card), .i_req_dest(req_dest), .i_req_amount(req_amount),
    .i_req_exp_date(req_date), .i_req_password(req_pw), .i_req_new_password(req_npw),
    .o_resp_valid(resp_valid), .o_resp_status(resp_status), .o_resp_balance(resp_balance),
    .o_resp_tx_count(resp_tx), .o_resp_last_amount(resp_last));

  typedef struct {int st; int bal; int tx; int last;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int m_bal[N], m_pw[N], m_tries[N], m_tx[N], m_last[N];
  bit m_ban[N];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bal[i] = 1000; m_pw[i] = i; m_tries[i] = 0; m_ban[i] = 0; m_tx[i] = 0; m_last[i] = 0;
    end
  endtask

  task automatic note(input int c, input int a);
    m_tx[c] = m_tx[c] < 255 ? m_tx[c] + 1 : 255;
    m_last[c] = a;
  endtask

  task automatic model(input int op, c, d, amt, date, p, np, output exp_t e);
    int s = 0;
    if (date < 2022) s = 1;
    else if (m_ban[c] && op != 6) s = 3;
    else if (m_pw[c] != p) begin
      s = 2;
      if (!m_ban[c]) begin
        m_tries[c]++;
        if (m_tries[c] >= 3) m_ban[c] = 1;
      end
    end else begin
      if (!m_ban[c]) m_tries[c] = 0;
      if (op == 0 || op == 7) s = 6;
    end
    if (s == 0) begin
      if (op == 2 && amt > 0) begin
        if (m_bal[c] - amt >= 100) begin m_bal[c] -= amt; note(c, amt); end
        else s = 4;
      end else if (op == 3) begin
        if (d == c) s = 5;
        else if (amt > 0) begin
          if (m_bal[c] - amt < 100) s = 4;
          else if (m_bal[d] + amt > AMAX) s = 7;
          else begin
            m_bal[c] -= amt; m_bal[d] += amt; note(c, amt); note(d, amt);
          end
        end
      end else if (op == 5) m_pw[c] = np;
      else if (op == 6 && m_ban[c]) begin
        if (m_bal[c] >= 100) begin
          m_bal[c] -= 100; m_ban[c] = 0; m_tries[c] = 0; note(c, 100);
        end else s = 4;
      end else if (op == 4) begin
`ifndef ATM_REPORT_EN
        s = 6;
`endif
      end
    end
    e.st = s;
    e.bal = m_bal[c];
    e.tx = (op == 4 && s == 0) ? m_tx[c] : 0;
    e.last = (op == 4 && s == 0) ? m_last[c] : 0;
  endtask

  task automatic drive(input int op, c, d, amt, date, p, np);
    req_op = 3'(op); req_card = 3'(c); req_dest = 3'(d); req_amount = AW'(amt);
    req_date = 11'(date); req_pw = 10'(p); req_npw = 10'(np); req_valid = 1;
  endtask

  task automatic issue(input int op, c, d, amt, date, p, np);
    exp_t e;
    @(negedge clk);
    chk("ready_idle", int'(req_ready), 1);
    drive(op, c, d, amt, date, p, np);
    @(posedge clk);
    #1 req_valid = 0;
    model(op, c, d, amt, date, p, np, e);
    q.push_back(e);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("ready_busy", int'(req_ready), 0);
      chk("resp_latency", int'(resp_valid), int'(k == 3));
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && resp_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got status %0d expected no response", resp_status);
      end else begin
        e = q.pop_front();
        chk("status", int'(resp_status), e.st);
        chk("balance", int'(resp_balance), e.bal);
        chk("tx_count", int'(resp_tx), e.tx);
        chk("last_amount", int'(resp_last), e.last);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_valid", int'(resp_valid), 0);
    chk("rst_status", int'(resp_status), 0);
    chk("rst_balance", int'(resp_balance), 0);
    chk("rst_tx", int'(resp_tx), 0);
    chk("rst_last", int'(resp_last), 0);
    issue(1, 3, 0, 0, 2023, 3, 0);
    issue(1, 3, 0, 0, 2020, 3, 0);
    issue(2, 3, 0, 901, 2023, 3, 0);
    issue(2, 3, 0, 900, 2023, 3, 0);
    issue(3, 5, 5, 10, 2023, 5, 0);
    issue(3, 5, 2, 90, 2023, 5, 0);
    issue(1, 2, 0, 0, 2023, 2, 0);
    issue(3, 0, 7, 900, 2023, 0, 0);
    issue(3, 1, 7, 147, 2023, 1, 0);
    issue(3, 1, 7, 1, 2023, 1, 0);
    issue(1, 7, 0, 0, 2022, 7, 0);
    issue(5, 4, 0, 0, 2023, 4, 1);
    issue(1, 4, 0, 0, 2023, 4, 0);
    issue(1, 4, 0, 0, 2023, 1, 0);
    issue(2, 4, 0, 10, 2023, 1, 0);
    issue(2, 4, 0, 15, 2023, 1, 0);
    issue(4, 4, 0, 0, 2023, 1, 0);
    issue(2, 4, 0, 0, 2023, 1, 0);
    issue(0, 2, 0, 0, 2023, 2, 0);
    issue(7, 2, 0, 0, 2023, 2, 0);
    repeat (3) issue(1, 6, 0, 0, 2023, 0, 0);
    issue(1, 6, 0, 0, 2023, 6, 0);
    issue(6, 6, 0, 0, 2023, 0, 0);
    issue(6, 6, 0, 0, 2023, 6, 0);
    issue(2, 6, 0, 750, 2023, 6, 0);
    repeat (3) issue(1, 6, 0, 0, 2023, 1, 0);
    issue(6, 6, 0, 0, 2023, 6, 0);
    repeat (3) issue(1, 6, 0, 0, 2023, 1, 0);
    issue(6, 6, 0, 0, 2023, 6, 0);
    issue(1, 6, 0, 0, 2023, 6, 0);
    issue(6, 3, 0, 0, 2023, 3, 0);
    @(negedge clk);
    drive(2, 0, 0, 100, 2023, 0, 0);
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk) rst_n = 0;
    @(negedge clk);
    chk("abort_ready", int'(req_ready), 1);
    chk("abort_valid", int'(resp_valid), 0);
    chk("abort_balance", int'(resp_balance), 0);
    @(negedge clk) rst_n = 1;
    model_reset();
    for (int i = 0; i < N; i++) issue(1, i, 0, 0, 2023, i, 0);
    for (int n = 0; n < 160; n++) begin
      int op, c, d, amt, date, p;
      op = $urandom_range(0, 7);
      c = $urandom_range(0, N - 1);
      d = $urandom_range(0, N - 1);
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 1200);
      date = $urandom_range(2019, 2026);
      p = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1023) : m_pw[c];
      issue(op, c, d, amt, date, p, $urandom_range(0, 15));
    end
    repeat (4) @(negedge clk);
    chk("pending", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
